// File: rtl/four_bit_signed_divider_if.sv
// four_bit_signed_divider_if: request/result bundle for the 4-bit signed divider
interface four_bit_signed_divider_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/four_bit_signed_divider.sv
// four_bit_signed_divider: 6-cycle restoring divider on magnitudes with sign fix-up
module four_bit_signed_divider (
  input logic clk,
  input logic reset,
  four_bit_signed_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIVIDE, FIX, DONE} state_t;
  state_t state;
  logic [3:0] q, m, a, dvd, dvs, fq, fr;
  logic [1:0] cnt;
  logic       sign_q, sign_r, dz, ov;
  logic [4:0] a_s, t;
  always_comb begin
    // a never exceeds 7 between iterations, so only the shifted partial remainder needs 5 bits
    a_s = {a, q[3]};
    t   = a_s + {1'b1, ~m} + 5'd1;
    dz  = dvs == 4'd0;
    ov  = !dz && dvd == 4'h8 && dvs == 4'hf;
    fq  = dz ? 4'hf : ov ? 4'h8 : sign_q ? 4'd0 - q : q;
    fr  = dz ? dvd : ov ? 4'd0 : sign_r ? 4'd0 - a : a;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      q               <= '0;
      m               <= '0;
      a               <= '0;
      dvd             <= '0;
      dvs             <= '0;
      cnt             <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state    <= DIVIDE;
            bus.busy <= 1'b1;
            dvd      <= bus.dividend;
            dvs      <= bus.divisor;
            q        <= bus.dividend[3] ? 4'd0 - bus.dividend : bus.dividend;
            m        <= bus.divisor[3] ? 4'd0 - bus.divisor : bus.divisor;
            sign_q   <= bus.dividend[3] ^ bus.divisor[3];
            sign_r   <= bus.dividend[3];
            a        <= '0;
            cnt      <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DIVIDE: begin
          a     <= t[4] ? a_s[3:0] : t[3:0];
          q     <= {q[2:0], ~t[4]};
          cnt   <= cnt + 2'd1;
          state <= cnt == 2'd3 ? FIX : DIVIDE;
        end
        FIX: begin
          state           <= DONE;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.quotient    <= fq;
          bus.remainder   <= fr;
          bus.div_by_zero <= dz;
          bus.overflow    <= ov;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_four_bit_signed_divider.sv
// tb_four_bit_signed_divider: directed vectors plus a full operand sweep against a signed model
module tb_four_bit_signed_divider;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  four_bit_signed_divider_if bus ();
  four_bit_signed_divider dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // issue one operation from idle/done; returns edges from accept to done and busy cycles seen
  task automatic op(input logic [3:0] a, input logic [3:0] b, output int lat, output int bcnt);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      tick();
      lat++;
    end
  endtask
  task automatic directed(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz, input logic eov);
    int lat, bcnt;
    op(a, b, lat, bcnt);
    check({tag, " latency"}, lat, 5);
    check({tag, " busy cycles"}, bcnt, 5);
    check({tag, " busy at done"}, bus.busy, 0);
    check({tag, " quotient"}, bus.quotient, eq);
    check({tag, " remainder"}, bus.remainder, er);
    check({tag, " div_by_zero"}, bus.div_by_zero, edz);
    check({tag, " overflow"}, bus.overflow, eov);
  endtask
  initial begin
    int lat, bcnt, saw;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);
    reset = 1'b0;
    tick();
    directed("7/2", 4'd7, 4'd2, 4'b0011, 4'b0001, 0, 0);
    tick();
    check("done pulse width", bus.done, 0);
    directed("-7/2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 0, 0);
    tick();
    directed("7/-2", 4'd7, 4'b1110, 4'b1101, 4'b0001, 0, 0);
    tick();
    directed("-6/-3", 4'b1010, 4'b1101, 4'b0010, 4'b0000, 0, 0);
    tick();
    directed("-8/-1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 0, 1);
    tick();
    directed("-8/1", 4'b1000, 4'b0001, 4'b1000, 4'b0000, 0, 0);
    tick();
    directed("5/0", 4'd5, 4'd0, 4'b1111, 4'b0101, 1, 0);
    // back-to-back: second start lands in the DONE cycle of the first
    directed("3/3 back-to-back", 4'd3, 4'd3, 4'b0001, 4'b0000, 0, 0);
    tick();
    // start held high with changing operands while busy
    bus.dividend = 4'd7;
    bus.divisor  = 4'd2;
    bus.start    = 1'b1;
    tick();
    lat = 0;
    while (!bus.done && lat < 20) begin
      bus.dividend = 4'(lat + 1);
      bus.divisor  = 4'(lat + 3);
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check("held start latency", lat, 5);
    check("held start quotient", bus.quotient, 4'b0011);
    check("held start remainder", bus.remainder, 4'b0001);
    tick();
    tick();
    // reset asserted at edge 3 of an operation
    bus.dividend = 4'd6;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset busy", bus.busy, 0);
    check("mid reset done", bus.done, 0);
    check("mid reset outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done || bus.busy) saw++;
      tick();
    end
    check("no done after reset", saw, 0);
    directed("6/3 after reset", 4'd6, 4'd3, 4'b0010, 4'b0000, 0, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        int ia, ib, iq, ir;
        logic [3:0] eq, er;
        logic edz, eov;
        ia  = int'($signed(4'(i)));
        ib  = int'($signed(4'(j)));
        edz = ib == 0;
        eov = ia == -8 && ib == -1;
        if (edz) begin
          iq = -1;
          ir = ia;
        end else if (eov) begin
          iq = -8;
          ir = 0;
        end else begin
          iq = ia / ib;
          ir = ia - iq * ib;
        end
        eq = 4'(iq);
        er = 4'(ir);
        op(4'(i), 4'(j), lat, bcnt);
        check($sformatf("sweep %0d/%0d latency", ia, ib), lat, 5);
        check($sformatf("sweep %0d/%0d quotient", ia, ib), bus.quotient, eq);
        check($sformatf("sweep %0d/%0d remainder", ia, ib), bus.remainder, er);
        check($sformatf("sweep %0d/%0d flags", ia, ib), {bus.div_by_zero, bus.overflow}, {edz, eov});
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
